// File: rtl/mig_regress_checker.sv
// ============================================================================
// mig_regress_checker
// ----------------------------------------------------------------------------
// Stimulus/response checker wrapped around a generated combinational netlist.
// On start it sweeps every input vector 0 .. 2^NUM_PI-1 onto pi_out, one per
// clock. It compares each response arriving on po_in, DUT_LAT cycles later,
// with the golden truth table TRUTH and reports the mismatch count and the
// first failing vector.
//
// Parameters:
//   NUM_PI   number of netlist primary inputs (1..10), sweep = 2^NUM_PI
//   TRUTH    golden truth table, bit v = expected output for vector v
//   DUT_LAT  register stages between pi_out and po_in (0..7)
//
// Ports:
//   clk             sole clock, rising edge
//   rst             synchronous active-high reset
//   start           begin a sweep (accepted only in IDLE or DONE)
//   pi_out          vector driven to the netlist inputs
//   po_in           netlist primary output
//   busy            sweep or drain in progress
//   done            result valid, held until next accepted start or rst
//   pass            done and no mismatch
//   err_cnt         mismatch count, saturates at 2^NUM_PI
//   first_fail      vector index of the first mismatch
//   first_fail_vld  at least one mismatch recorded
//   sig             CRC-16 of all compared responses (REGRESS_SIG_EN only)
//
// Optional feature macro: REGRESS_SIG_EN adds the sig port and the response
// signature logic. Without it the block is complete and sig does not exist.
// ============================================================================
module mig_regress_checker #(
    parameter int unsigned                NUM_PI  = 5,
    parameter logic [(1<<NUM_PI)-1:0]     TRUTH   = '0,
    parameter int unsigned                DUT_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [NUM_PI-1:0] pi_out,
    input  logic              po_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [NUM_PI:0]   err_cnt,
    output logic [NUM_PI-1:0] first_fail,
    output logic              first_fail_vld
`ifdef REGRESS_SIG_EN
    ,
    output logic [15:0]       sig
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [NUM_PI-1:0] LAST_VEC   = '1;
    localparam logic [NUM_PI:0]   ERR_MAX    = {1'b1, {NUM_PI{1'b0}}};
    localparam logic [2:0]        DRAIN_INIT = 3'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

    state_t              r_state;
    logic [NUM_PI-1:0]   r_pi;
    logic                r_busy;
    logic                r_done;
    logic [NUM_PI:0]     r_err;
    logic [NUM_PI-1:0]   r_ff;
    logic                r_ffv;
    logic [2:0]          r_drain;
`ifdef REGRESS_SIG_EN
    logic [15:0]         r_sig;
`endif

    // Entry of the compare pipeline: the vector on pi_out is a real stimulus
    // only while sweeping.
    logic                w_in_vld;
    logic                w_tap_vld;
    logic [NUM_PI-1:0]   w_tap_idx;
    logic                w_mismatch;

    assign w_in_vld = (r_state == S_DRIVE);

    generate
        if (DUT_LAT == 0) begin : g_no_lat
            // Netlist is purely combinational: response belongs to pi_out now.
            assign w_tap_vld = w_in_vld;
            assign w_tap_idx = r_pi;
        end else begin : g_lat
            logic [DUT_LAT-1:0] r_vld;
            logic [NUM_PI-1:0]  r_idx [DUT_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_in_vld;
                    for (int i = 1; i < int'(DUT_LAT); i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            // NOTE: index stages carry data qualified by r_vld, so they are
            // deliberately left out of reset.
            always_ff @(posedge clk) begin
                r_idx[0] <= r_pi;
                for (int i = 1; i < int'(DUT_LAT); i++) begin
                    r_idx[i] <= r_idx[i-1];
                end
            end

            assign w_tap_vld = r_vld[DUT_LAT-1];
            assign w_tap_idx = r_idx[DUT_LAT-1];
        end
    endgenerate

    assign w_mismatch = w_tap_vld && (po_in != TRUTH[w_tap_idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pi    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= '0;
            r_ff    <= '0;
            r_ffv   <= 1'b0;
            r_drain <= '0;
`ifdef REGRESS_SIG_EN
            r_sig   <= '0;
`endif
        end else begin
            // Result accumulation runs on the pipeline tap, independent of
            // which sweep phase the counter is in.
            if (w_mismatch) begin
                if (r_err != ERR_MAX) begin
                    r_err <= r_err + 1'b1;
                end
                if (!r_ffv) begin
                    r_ff  <= w_tap_idx;
                    r_ffv <= 1'b1;
                end
            end
`ifdef REGRESS_SIG_EN
            if (w_tap_vld) begin
                r_sig <= {r_sig[14:0], 1'b0} ^ ((r_sig[15] ^ po_in) ? 16'h1021 : 16'h0000);
            end
`endif

            case (r_state)
                S_IDLE, S_DONE: begin
                    // No compare is in flight here, so these clears never
                    // collide with an accumulation update above.
                    if (start) begin
                        r_state <= S_DRIVE;
                        r_pi    <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= '0;
                        r_ff    <= '0;
                        r_ffv   <= 1'b0;
`ifdef REGRESS_SIG_EN
                        r_sig   <= 16'hFFFF;
`endif
                    end
                end
                S_DRIVE: begin
                    if (r_pi == LAST_VEC) begin
                        // Last vector stays on pi_out; no wrap.
                        if (DUT_LAT == 0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                            r_drain <= DRAIN_INIT;
                        end
                    end else begin
                        r_pi <= r_pi + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Wait for the last DUT_LAT responses to reach the tap.
                    if (r_drain == 3'd0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pi_out         = r_pi;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err_cnt        = r_err;
    assign first_fail     = r_ff;
    assign first_fail_vld = r_ffv;
    assign pass           = r_done && (r_err == '0);
`ifdef REGRESS_SIG_EN
    assign sig            = r_sig;
`endif

endmodule
